// File: rtl/ps2_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_cmd_ctrl: host-to-device PS/2 command sequencer (inhibit, frame,       |
// | ACK bit, response byte). Define PS2_CMD_RETRY_EN to resend on 0xFE.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ps2_cmd_ctrl #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRY      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ready,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       ps2_clk_low,
  output logic       ps2_data_low,
  output logic       rx_hold,
  output logic       done,
  output logic       err,
  output logic [7:0] resp
);

  localparam int c_MAX_CYC = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int c_CNT_W   = $clog2(c_MAX_CYC) + 1;
  localparam logic [c_CNT_W-1:0] c_INH_LAST = c_CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] c_ACK = 8'hFA;

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_INHIBIT = 3'd1;
  localparam logic [2:0] c_ST_START   = 3'd2;
  localparam logic [2:0] c_ST_ACKBIT  = 3'd3;
  localparam logic [2:0] c_ST_RESP    = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic               r_clk_cur;
  logic               r_clk_prev;
  logic [c_CNT_W-1:0] r_cnt;
  logic [9:0]         r_shift;
  logic [3:0]         r_bit;
  logic               r_data_low;
  logic [7:0]         r_byte;
  logic [7:0]         r_resp;
  logic               w_neg_edge;
  logic               w_phase;
  logic               w_rx_resp;
  logic               w_timeout;
  logic               w_resend;

  assign w_neg_edge = r_clk_prev & ~r_clk_cur;
  assign w_phase    = (r_state == c_ST_START) | (r_state == c_ST_ACKBIT) | (r_state == c_ST_RESP);
  assign w_rx_resp  = (r_state == c_ST_RESP) & rx_valid;
  // A qualifying event in the expiry cycle takes priority over the timeout.
  assign w_timeout  = w_phase & (r_cnt == c_TO_LAST) & ~w_neg_edge & ~w_rx_resp;
  assign resp       = r_resp;

`ifdef PS2_CMD_RETRY_EN
  localparam int         c_RTY_W  = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [7:0] c_RESEND = 8'hFE;
  logic [c_RTY_W-1:0] r_retry;

  assign w_resend = (rx_byte == c_RESEND) & (r_retry < c_RTY_W'(MAX_RETRY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retry <= '0;
    end else if ((r_state == c_ST_IDLE) && cmd_valid) begin
      r_retry <= '0;
    end else if (w_rx_resp && w_resend) begin
      r_retry <= r_retry + c_RTY_W'(1);
    end
  end
`else
  assign w_resend = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE:    if (cmd_valid) w_next = c_ST_INHIBIT;
      c_ST_INHIBIT: if (r_cnt == c_INH_LAST) w_next = c_ST_START;
      c_ST_START: begin
        if (w_timeout) w_next = c_ST_IDLE;
        else if (w_neg_edge && (r_bit == 4'd9)) w_next = c_ST_ACKBIT;
      end
      c_ST_ACKBIT: begin
        if (w_timeout) w_next = c_ST_IDLE;
        else if (w_neg_edge) w_next = ps2_data ? c_ST_IDLE : c_ST_RESP;
      end
      c_ST_RESP: begin
        if (w_timeout) w_next = c_ST_IDLE;
        else if (rx_valid) w_next = w_resend ? c_ST_INHIBIT : c_ST_IDLE;
      end
      default: w_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready    = 1'b0;
    rx_hold      = 1'b1;
    ps2_clk_low  = 1'b0;
    ps2_data_low = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        cmd_ready = 1'b1;
        rx_hold   = 1'b0;
      end
      c_ST_INHIBIT: begin
        ps2_clk_low  = 1'b1;
        ps2_data_low = (r_cnt == c_INH_LAST);
      end
      c_ST_START: begin
        ps2_data_low = r_data_low & ~w_timeout;
        err          = w_timeout;
      end
      c_ST_ACKBIT: err = w_timeout | (w_neg_edge & ps2_data);
      c_ST_RESP: begin
        done = rx_valid & (rx_byte == c_ACK);
        err  = w_timeout | (rx_valid & (rx_byte != c_ACK) & ~w_resend);
      end
      default: ;
    endcase
  end

  // Idle-high line history so reset never fakes a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_cur  <= 1'b1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_cur  <= ps2_clk;
      r_clk_prev <= r_clk_cur;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if ((w_next != r_state) || (r_state == c_ST_IDLE) || (w_phase && w_neg_edge)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  // Frame is rebuilt from the latched byte on every START entry, covering resends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte     <= '0;
      r_shift    <= '0;
      r_bit      <= '0;
      r_data_low <= 1'b0;
      r_resp     <= '0;
    end else begin
      if ((r_state == c_ST_IDLE) && cmd_valid) r_byte <= cmd_byte;
      if ((r_state == c_ST_INHIBIT) && (r_cnt == c_INH_LAST)) begin
        r_shift    <= {1'b1, ~^r_byte, r_byte};
        r_bit      <= '0;
        r_data_low <= 1'b1;
      end else if ((r_state == c_ST_START) && w_neg_edge) begin
        r_data_low <= ~r_shift[0];
        r_shift    <= {1'b0, r_shift[9:1]};
        r_bit      <= r_bit + 4'd1;
      end
      if (w_rx_resp) r_resp <= rx_byte;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ps2_cmd_ctrl: keyboard-side model and scoreboard for ps2_cmd_ctrl.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ps2_cmd_ctrl;

  localparam int INH  = 5000;
  localparam int TO   = 2000;
  localparam int MAXR = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       cmd_ready;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       ps2_clk_low;
  logic       ps2_data_low;
  logic       rx_hold;
  logic       done;
  logic       err;
  logic [7:0] resp;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int n_err    = 0;
  int n_both   = 0;
  int n_acc    = 0;
  logic [7:0] exp_resp = 8'h00;

  always #5 clk = ~clk;

  ps2_cmd_ctrl #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRY     (MAXR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .cmd_valid   (cmd_valid),
    .cmd_byte    (cmd_byte),
    .cmd_ready   (cmd_ready),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .ps2_clk_low (ps2_clk_low),
    .ps2_data_low(ps2_data_low),
    .rx_hold     (rx_hold),
    .done        (done),
    .err         (err),
    .resp        (resp)
  );

  // Pulse and handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (done) n_done <= n_done + 1;
    if (err) n_err <= n_err + 1;
    if (done && err) n_both <= n_both + 1;
    if (cmd_valid && cmd_ready) n_acc <= n_acc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One device clock pulse; returns the data line level seen while clock is low.
  task automatic clock_edge(input int lo, input int hi, output logic line);
    @(posedge clk); #1 ps2_clk = 1'b0;
    repeat (lo) @(negedge clk);
    line = ~ps2_data_low;
    @(posedge clk); #1 ps2_clk = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  // mode 0: normal, 1: device never clocks, 2: reset after the 5th edge.
  task automatic run_txn(input logic [7:0] b, input int mode, input logic ack_bit,
                         input logic [23:0] rsps, input bit hold, input bit inject);
    int d0, e0, a0, n, ri, retries, inh_len, exp_done, exp_err;
    logic fin, aborted, line, dl_first, dl_last;
    logic [7:0] r;
    logic [9:0] frame, exp_frame;
    exp_frame = {1'b1, ($countones(b) % 2 == 0), b};
    d0 = n_done; e0 = n_err; a0 = n_acc;
    exp_done = 0; exp_err = 0; retries = 0; ri = 0; fin = 1'b0; aborted = 1'b0;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1 cmd_valid = 1'b1; cmd_byte = b;
    @(posedge clk); #1 cmd_byte = ~b; if (!hold) cmd_valid = 1'b0;
    while (!fin) begin
      @(negedge clk);
      n = 0;
      while (!ps2_clk_low && n < 20) begin @(negedge clk); n++; end
      inh_len = 0; dl_first = ps2_data_low; dl_last = 1'b0;
      while (ps2_clk_low && inh_len < INH + 20) begin
        dl_last = ps2_data_low;
        inh_len++;
        @(negedge clk);
      end
      check("inhibit_len", inh_len, INH);
      check("inhibit_data", {dl_first, dl_last, ps2_data_low, rx_hold}, 4'b0111);
      if (mode == 1) begin
        n = 1;
        while (!err && n < TO + 20) begin @(negedge clk); n++; end
        check("timeout_len", n, TO);
        check("timeout_release", {ps2_clk_low, ps2_data_low}, 2'b00);
        @(negedge clk);
        check("ready_after_timeout", cmd_ready, 1);
        exp_err = 1; fin = 1'b1;
      end else begin
        if (inject) begin
          @(posedge clk); #1 rx_valid = 1'b1; rx_byte = 8'h1C;
          @(posedge clk); #1 rx_valid = 1'b0;
          repeat (2) @(negedge clk);
          check("rx_ignored", resp, exp_resp);
        end
        frame = '0;
        for (int e = 0; e < 10 && !aborted; e++) begin
          clock_edge($urandom_range(4, 12), $urandom_range(4, 12), line);
          frame[e] = line;
          if (mode == 2 && e == 4) begin
            #2 rst_n = 1'b0;
            #1 check("reset_release", {cmd_ready, rx_hold, ps2_clk_low, ps2_data_low}, 4'b1000);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            exp_resp = 8'h00; aborted = 1'b1; fin = 1'b1;
          end
        end
        if (!aborted) begin
          check("frame", frame, exp_frame);
          ps2_data = ack_bit;
          clock_edge(6, 6, line);
          ps2_data = 1'b1;
          if (ack_bit) begin
            exp_err = 1; fin = 1'b1;
          end else begin
            cmd_valid = 1'b0;
            r = rsps[8*ri +: 8];
            ri++;
            @(posedge clk); #1 rx_valid = 1'b1; rx_byte = r;
            @(posedge clk); #1 rx_valid = 1'b0;
            exp_resp = r;
            if (r == 8'hFA) begin
              exp_done = 1; fin = 1'b1;
            end
`ifdef PS2_CMD_RETRY_EN
            else if (r == 8'hFE && retries < MAXR) begin
              retries++;
            end
`endif
            else begin
              exp_err = 1; fin = 1'b1;
            end
          end
        end
      end
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("done_pulses", n_done - d0, exp_done);
    check("err_pulses", n_err - e0, exp_err);
    check("accepts", n_acc - a0, 1);
    check("resp", resp, exp_resp);
    check("idle_outputs", {cmd_ready, rx_hold, ps2_clk_low, ps2_data_low, done, err}, 6'b100000);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] rb, rr;
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    cmd_valid = 1'b0; cmd_byte = 8'h00; rx_valid = 1'b0; rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", {cmd_ready, rx_hold, ps2_clk_low, ps2_data_low, done, err}, 6'b100000);
    check("reset_resp", resp, 0);
    rst_n = 1'b1;

    run_txn(8'hED, 0, 1'b0, 24'h0000FA, 1'b0, 1'b0);
    run_txn(8'h00, 0, 1'b1, 24'h0000FA, 1'b0, 1'b0);
    rb = 8'($urandom_range(0, 255));
    run_txn(rb, 1, 1'b0, 24'h000000, 1'b0, 1'b0);
    run_txn(8'hF3, 0, 1'b0, 24'hFAFEFE, 1'b0, 1'b0);
    rb = 8'($urandom_range(0, 255));
    run_txn(rb, 2, 1'b0, 24'h0000FA, 1'b0, 1'b0);
    rb = 8'($urandom_range(0, 255));
    run_txn(rb, 0, 1'b0, 24'h0000FA, 1'b0, 1'b0);
    rb = 8'($urandom_range(0, 255));
    run_txn(rb, 0, 1'b0, 24'h0000FA, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      rb = 8'($urandom_range(0, 255));
      rr = ($urandom_range(0, 1) == 0) ? 8'hFA : 8'($urandom_range(0, 255));
      if (rr == 8'hFE) rr = 8'h55;
      run_txn(rb, 0, ($urandom_range(0, 3) == 0), {16'h0000, rr}, 1'b0, 1'b0);
    end

    check("done_err_overlap", n_both, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_cmd_ctrl.md
Name: ps2_cmd_ctrl

Overview:
- Host-to-device command sequencer for the PS/2 keyboard port, e.g. 0xED + LED mask, or 0xFF reset.
- Owns the open-drain drive of ps2_clk/ps2_data and serialises one command byte at a time.
- Waits for the keyboard's response byte from the existing receive path and holds that path's display update off while a transaction is in flight.
- Sits beside the PS/2 receiver; a top-level FSM or switches feed it commands.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles the clock line is held low before the start bit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000: clk cycles allowed per phase (device clocking, ACK bit, response byte) before abort.
- MAX_RETRY, 2: resend attempts on 0xFE response; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ps2_clk  in  1  debounced keyboard clock line (sensed)
- ps2_data  in  1  keyboard data line (sensed)
- cmd_valid  in  1  command request
- cmd_byte  in  8  command byte to send
- cmd_ready  out  1  high in IDLE only; transfer when cmd_valid & cmd_ready
- rx_valid  in  1  one-cycle pulse from receiver: byte received
- rx_byte  in  8  received scan byte (frame bits [8:1])
- ps2_clk_low  out  1  1 = drive clock line low, 0 = release
- ps2_data_low  out  1  1 = drive data line low, 0 = release
- rx_hold  out  1  high in every state except IDLE; receiver must not update display_data
- done  out  1  one-cycle pulse: 0xFA received
- err  out  1  one-cycle pulse: timeout, missing ACK bit, or unrecoverable response
- resp  out  8  last response byte captured

Behaviour:
- Reset: state IDLE, all counters 0; cmd_ready=1, ps2_clk_low=0, ps2_data_low=0, rx_hold=0, done=0, err=0, resp=8'h00.
- Falling-edge detect: two-register history of ps2_clk (prev/cur). neg_edge = prev & ~cur, one cycle of clk, 2 cycles after the line falls.
- Shift register on accept: {1'b1 stop, odd parity = ~^cmd_byte, cmd_byte}, sent LSB first. Bit counter is 4 bits and counts falling edges.

States:
- IDLE: cmd_ready=1. On accept: latch byte, clear retry count, go to INHIBIT.
- INHIBIT: ps2_clk_low=1 for exactly INHIBIT_CYCLES clk cycles; ps2_data_low asserted in the last cycle. Then go to START.
- START: release clock, keep data low (start bit), clear timeout counter. Each neg_edge drives the next shift bit: data_low = ~bit.
  - Edges 1–8 drive data bits, edge 9 drives parity, edge 10 releases data (stop).
  - After edge 10, go to ACKBIT.
- ACKBIT: on next neg_edge, sample ps2_data. 0 = ACK, go to RESP; 1 = err pulse, go to IDLE.
- RESP: wait for rx_valid and capture resp=rx_byte.
  - 0xFA: done pulse, go to IDLE.
  - 0xFE: see optional feature.
  - Any other value: err pulse, go to IDLE.
- Timeout: the counter resets on entering START/ACKBIT/RESP and on every neg_edge. Reaching TIMEOUT_CYCLES-1 in those states gives an err pulse, releases both lines the same cycle, and returns to IDLE.
- rx_valid outside RESP is ignored.
- cmd_valid while busy is not accepted and stays pending.
- done and err are never asserted together.
- Reset mid-transaction releases both lines immediately (asynchronously).

Optional Feature:
- PS2_CMD_RETRY_EN defined: 0xFE in RESP increments the retry count.
  - If count ≤ MAX_RETRY, go back to INHIBIT with the same latched byte.
  - Otherwise, err pulse.
- Not defined: 0xFE gives an immediate err pulse; the retry counter and MAX_RETRY logic are absent.

Test Plan:
- Send 0xED, device model clocks 11 edges, ACK low, rx 0xFA -> data bits 1,0,1,1,0,1,1,1 sent LSB first, parity 1; clock held low exactly 5000 cycles; done=1 one cycle; resp=0xFA; rx_hold low after.
- Send 0x00 -> parity bit driven 1 (data released), stop released; ACK bit 1 from model -> err pulse, state IDLE, both lines released.
- Command accepted, model never clocks -> err pulse exactly TIMEOUT_CYCLES after START entry; cmd_ready=1 next cycle.
- Response 0xFE twice then 0xFA, with PS2_CMD_RETRY_EN -> three INHIBIT phases, single done. Without the macro -> err after first 0xFE.
- rst_n low during bit 5 -> ps2_clk_low=0, ps2_data_low=0, cmd_ready=1 immediately; next command completes normally.
- cmd_valid held during busy, rx_valid 0x1C during START -> no second accept until IDLE; 0x1C not captured in resp.
